// File: rtl/pause_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pause_ctrl
//  Description : Merges user, OSD and external pause requests into one CPU
//                pause, with frame-aligned soft pauses, single-frame stepping
//                and timed video dimming.
//  Revision    : 1.0 - initial release
// ============================================================================
module pause_ctrl #(
    parameter int RW         = 4,
    parameter int GW         = 4,
    parameter int BW         = 4,
    parameter int NREQ       = 2,
    parameter int DIM_CYCLES = 480000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  frame_step,
    input  logic [NREQ-1:0]       pause_request,
    input  logic                  OSD_STATUS,
    input  logic [1:0]            options,
    input  logic                  vblank,
    input  logic [RW+GW+BW-1:0]   rgb_in,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dim_active
);

    localparam int              c_PW  = RW + GW + BW;
    localparam int              c_CW  = $clog2(DIM_CYCLES + 1);
    localparam logic [c_CW-1:0] c_DIM = c_CW'(DIM_CYCLES);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_PEND   = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;
    localparam logic [1:0] c_ST_STEP   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_btn_d;
    logic            r_step_d;
    logic            r_vblank_d;
    logic            r_user_pause;
    logic [c_CW-1:0] r_dim_cnt;
    logic [c_CW-1:0] w_dim_cnt_next;
    logic            w_pause_next;
    logic            w_dim_next;
    logic [c_PW-1:0] w_rgb_next;

    logic w_soft_req;
    logic w_hard_req;
    logic w_vb_rise;
    logic w_step_rise;
    logic w_btn_rise;

    logic [RW-1:0] w_r;
    logic [GW-1:0] w_g;
    logic [BW-1:0] w_b;

    assign w_btn_rise  = user_button & ~r_btn_d;
    assign w_step_rise = frame_step & ~r_step_d;
    assign w_vb_rise   = vblank & ~r_vblank_d;
    assign w_soft_req  = r_user_pause | (OSD_STATUS & options[0]);
    assign w_hard_req  = |pause_request;

    assign w_r = rgb_in[c_PW-1 -: RW];
    assign w_g = rgb_in[GW+BW-1 -: GW];
    assign w_b = rgb_in[BW-1:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= c_ST_RUN;
            r_btn_d      <= 1'b0;
            r_step_d     <= 1'b0;
            r_vblank_d   <= 1'b0;
            r_user_pause <= 1'b0;
            r_dim_cnt    <= '0;
            pause_cpu    <= 1'b0;
            dim_active   <= 1'b0;
            rgb_out      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_btn_d    <= user_button;
            r_step_d   <= frame_step;
            r_vblank_d <= vblank;
            if (w_btn_rise) begin
                r_user_pause <= ~r_user_pause;
            end
            r_dim_cnt  <= w_dim_cnt_next;
            pause_cpu  <= w_pause_next;
            dim_active <= w_dim_next;
            rgb_out    <= w_rgb_next;
        end
    end

    // External requests always win; soft pauses wait for the next vblank.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_hard_req)      w_state_next = c_ST_PAUSED;
                else if (w_soft_req) w_state_next = c_ST_PEND;
            end
            c_ST_PEND, c_ST_STEP: begin
                if (w_hard_req)      w_state_next = c_ST_PAUSED;
                else if (!w_soft_req) w_state_next = c_ST_RUN;
                else if (w_vb_rise)  w_state_next = c_ST_PAUSED;
            end
            c_ST_PAUSED: begin
                if (!w_soft_req && !w_hard_req)   w_state_next = c_ST_RUN;
                else if (w_step_rise && !w_hard_req) w_state_next = c_ST_STEP;
            end
            default: w_state_next = c_ST_RUN;
        endcase
    end

    // Dim flag and halved pixel are derived from the same next-cycle value
    // so they switch together.
    always_comb begin
        w_dim_cnt_next = '0;
        if (r_state == c_ST_PAUSED && r_user_pause) begin
            w_dim_cnt_next = (r_dim_cnt == c_DIM) ? r_dim_cnt : r_dim_cnt + c_CW'(1);
        end
        w_pause_next = (w_state_next == c_ST_PAUSED);
        w_dim_next   = options[1] & (w_dim_cnt_next == c_DIM);
        w_rgb_next   = rgb_in;
        if (w_dim_next) begin
            w_rgb_next = {1'b0, w_r[RW-1:1], 1'b0, w_g[GW-1:1], 1'b0, w_b[BW-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pause_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pause_ctrl
//  Description : Directed bench for pause_ctrl with a cycle-tagged scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pause_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        user_button;
    logic        frame_step;
    logic [1:0]  pause_request;
    logic        OSD_STATUS;
    logic [1:0]  options;
    logic        vblank;
    logic [11:0] rgb_in;
    logic [11:0] rgb_out;
    logic        pause_cpu;
    logic        dim_active;

    pause_ctrl #(
        .RW(4), .GW(4), .BW(4), .NREQ(2), .DIM_CYCLES(100)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .user_button   (user_button),
        .frame_step    (frame_step),
        .pause_request (pause_request),
        .OSD_STATUS    (OSD_STATUS),
        .options       (options),
        .vblank        (vblank),
        .rgb_in        (rgb_in),
        .rgb_out       (rgb_out),
        .pause_cpu     (pause_cpu),
        .dim_active    (dim_active)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        int          id;
        logic        pause;
        logic        dim;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Monitor: compares every expectation tagged for the current cycle.
    always @(negedge clk_sys) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || pause_cpu !== e.pause || dim_active !== e.dim || rgb_out !== e.rgb) begin
                errors++;
                $display("FAIL chk%0d cyc=%0d: got pause=%b dim=%b rgb=%h, need pause=%b dim=%b rgb=%h",
                         e.id, cyc, pause_cpu, dim_active, rgb_out, e.pause, e.dim, e.rgb);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic expect_out(input logic p, input logic d, input logic [11:0] rgb);
        exp_t e;
        e.cyc   = cyc;
        e.id    = next_id;
        e.pause = p;
        e.dim   = d;
        e.rgb   = rgb;
        next_id++;
        q.push_back(e);
    endtask

    task automatic press_button();
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        step();
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
    endtask

    initial begin
        reset = 1'b1; user_button = 1'b0; frame_step = 1'b0; pause_request = 2'b00;
        OSD_STATUS = 1'b0; options = 2'b00; vblank = 1'b0; rgb_in = 12'hF8A;
        step(2);
        expect_out(1'b0, 1'b0, 12'h000);
        reset = 1'b0;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);

        // User pause waits for the frame boundary, unpause does not
        user_button = 1'b1;
        step(3);
        user_button = 1'b0;
        step(2);
        expect_out(1'b0, 1'b0, 12'hF8A);
        vblank_pulse();
        expect_out(1'b1, 1'b0, 12'hF8A);
        step(3);
        user_button = 1'b1;
        step();
        expect_out(1'b1, 1'b0, 12'hF8A);
        user_button = 1'b0;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);

        // External request: immediate in both directions
        step(2);
        pause_request = 2'b10;
        step();
        expect_out(1'b1, 1'b0, 12'hF8A);
        pause_request = 2'b00;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);

        // Frame stepping
        press_button();
        vblank_pulse();
        expect_out(1'b1, 1'b0, 12'hF8A);
        step();
        frame_step = 1'b1;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);
        frame_step = 1'b0;
        step(3);
        expect_out(1'b0, 1'b0, 12'hF8A);
        vblank_pulse();
        expect_out(1'b1, 1'b0, 12'hF8A);
        step();
        pause_request = 2'b01;
        step();
        frame_step = 1'b1;
        step();
        expect_out(1'b1, 1'b0, 12'hF8A);
        step();
        expect_out(1'b1, 1'b0, 12'hF8A);
        frame_step = 1'b0;
        pause_request = 2'b00;
        step();
        expect_out(1'b1, 1'b0, 12'hF8A);

        // Dimming after exactly 100 paused cycles
        options = 2'b10;
        press_button();
        expect_out(1'b0, 1'b0, 12'hF8A);
        press_button();
        vblank_pulse();
        expect_out(1'b1, 1'b0, 12'hF8A);
        step(99);
        expect_out(1'b1, 1'b0, 12'hF8A);
        step();
        expect_out(1'b1, 1'b1, 12'h745);
        rgb_in = 12'h123;
        step();
        expect_out(1'b1, 1'b1, 12'h011);
        rgb_in = 12'hF8A;
        user_button = 1'b1;
        step();
        expect_out(1'b1, 1'b1, 12'h745);
        user_button = 1'b0;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);

        // OSD pause enabled, then disabled
        options = 2'b01;
        OSD_STATUS = 1'b1;
        step(2);
        expect_out(1'b0, 1'b0, 12'hF8A);
        vblank_pulse();
        expect_out(1'b1, 1'b0, 12'hF8A);
        OSD_STATUS = 1'b0;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);
        options = 2'b00;
        OSD_STATUS = 1'b1;
        step(2);
        vblank_pulse();
        expect_out(1'b0, 1'b0, 12'hF8A);
        step();
        OSD_STATUS = 1'b0;

        // Dim disabled: long user pause never dims
        press_button();
        vblank_pulse();
        step(110);
        expect_out(1'b1, 1'b0, 12'hF8A);
        press_button();
        expect_out(1'b0, 1'b0, 12'hF8A);

        // Reset while stepping with a running dim timer
        options = 2'b10;
        press_button();
        vblank_pulse();
        step(10);
        frame_step = 1'b1;
        step();
        expect_out(1'b0, 1'b0, 12'hF8A);
        reset = 1'b1;
        frame_step = 1'b0;
        step();
        expect_out(1'b0, 1'b0, 12'h000);
        reset = 1'b0;
        step();
        vblank_pulse();
        expect_out(1'b0, 1'b0, 12'hF8A);
        step(2);
        expect_out(1'b0, 1'b0, 12'hF8A);

        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending, need 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
